// File: rtl/sip_xnor_acc_ctrl_if.sv
// Bus between the tile scheduler, the XNOR dot datapath and sip_xnor_acc_ctrl.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid may
// not depend on ready, and the producer holds data stable while valid is high and ready is low.
interface sip_xnor_acc_ctrl_if #(
  parameter int ACC_W              = 24,
  parameter int CNT_W              = 8,
  parameter int BITS_ACT           = 16,
  parameter int BITS_WEIGHT        = 16,
  parameter int BITS_SIP_DOT_ADDER = 12
);
  logic                                 i_Start;
  logic        [CNT_W-1:0]              i_NumChunks;
  logic                                 i_Mode;
  logic                                 i_SignI;
  logic                                 i_Bin;
  logic                                 i_InValid;
  logic                                 o_InReady;
  logic        [BITS_ACT-1:0]           i_Act;
  logic        [BITS_WEIGHT-1:0]        i_Weight;
  logic        [BITS_ACT-1:0]           o_Act;
  logic        [BITS_WEIGHT-1:0]        o_Weight;
  logic                                 o_Mode;
  logic                                 o_SignI;
  logic                                 o_Bin;
  logic signed [BITS_SIP_DOT_ADDER-1:0] i_DotSum;
  logic                                 o_OutValid;
  logic                                 i_OutReady;
  logic signed [ACC_W-1:0]              o_Result;
  logic                                 o_Sat;
  logic                                 o_Busy;

  modport master (
    output i_Start, i_NumChunks, i_Mode, i_SignI, i_Bin, i_InValid, i_Act, i_Weight,
           i_DotSum, i_OutReady,
    input  o_InReady, o_Act, o_Weight, o_Mode, o_SignI, o_Bin, o_OutValid, o_Result,
           o_Sat, o_Busy
  );

  modport slave (
    input  i_Start, i_NumChunks, i_Mode, i_SignI, i_Bin, i_InValid, i_Act, i_Weight,
           i_DotSum, i_OutReady,
    output o_InReady, o_Act, o_Weight, o_Mode, o_SignI, o_Bin, o_OutValid, o_Result,
           o_Sat, o_Busy
  );
endinterface

// File: rtl/sip_xnor_acc_ctrl.sv
// Job sequencer for the XNOR SIP dot datapath: streams NumChunks operand pairs through
// registered outputs and saturating-accumulates the returned dot sums into one result.
module sip_xnor_acc_ctrl #(
  parameter int ACC_W              = 24,
  parameter int CNT_W              = 8,
  parameter int BITS_ACT           = 16,
  parameter int BITS_WEIGHT        = 16,
  parameter int BITS_SIP_DOT_ADDER = 12
) (
  input  logic                i_CLK,
  input  logic                i_RSTn,
  sip_xnor_acc_ctrl_if.slave  bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         num_q, cnt_q;
  logic [CNT_W:0]           cnt_inc;
  logic [BITS_ACT-1:0]      act_q;
  logic [BITS_WEIGHT-1:0]   weight_q;
  logic                     mode_q, sign_i_q, bin_q;
  logic                     op_valid_q;
  logic [ACC_W-1:0]         acc_q, acc_next;
  logic [ACC_W:0]           sum_wide;
  logic                     acc_clamp;
  logic                     sat_q, busy_q;
  logic                     chunk_hs, start_hs;

  assign chunk_hs = (state_q == S_RUN) && bus.i_InValid;
  assign start_hs = (state_q == S_IDLE) && bus.i_Start;
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_Start) state_d = (bus.i_NumChunks == '0) ? S_DONE : S_RUN;
      S_RUN:   if (chunk_hs && (cnt_inc == {1'b0, num_q})) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (bus.i_OutReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One guard bit above the accumulator: overflow shows as the top two bits disagreeing.
  always_comb begin
    sum_wide  = {acc_q[ACC_W-1], acc_q}
              + {{(ACC_W + 1 - BITS_SIP_DOT_ADDER){bus.i_DotSum[BITS_SIP_DOT_ADDER-1]}},
                 bus.i_DotSum};
    acc_clamp = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_next  = sum_wide[ACC_W-1:0];
    if (acc_clamp) begin
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      num_q      <= '0;
      cnt_q      <= '0;
      act_q      <= '0;
      weight_q   <= '0;
      mode_q     <= 1'b0;
      sign_i_q   <= 1'b0;
      bin_q      <= 1'b0;
      op_valid_q <= 1'b0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != S_IDLE);
      op_valid_q <= chunk_hs;
      if (start_hs) begin
        num_q    <= bus.i_NumChunks;
        cnt_q    <= '0;
        mode_q   <= bus.i_Mode;
        sign_i_q <= bus.i_SignI;
        bin_q    <= bus.i_Bin;
        acc_q    <= '0;
        sat_q    <= 1'b0;
      end
      if (chunk_hs) begin
        act_q    <= bus.i_Act;
        weight_q <= bus.i_Weight;
        cnt_q    <= cnt_inc[CNT_W-1:0];
      end
      // The dot sum for the operands registered last edge is valid now.
      if (op_valid_q) begin
        acc_q <= acc_next;
        if (acc_clamp) sat_q <= 1'b1;
      end
    end
  end

  assign bus.o_InReady  = (state_q == S_RUN);
  assign bus.o_OutValid = (state_q == S_DONE);
  assign bus.o_Act      = act_q;
  assign bus.o_Weight   = weight_q;
  assign bus.o_Mode     = mode_q;
  assign bus.o_SignI    = sign_i_q;
  assign bus.o_Bin      = bin_q;
  assign bus.o_Result   = acc_q;
  assign bus.o_Sat      = sat_q;
  assign bus.o_Busy     = busy_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_sip_xnor_acc_ctrl.sv
// Bench for sip_xnor_acc_ctrl with an 8-bit accumulator and a stub datapath whose dot sum
// is the signed low byte of act ^ weight.
module tb_sip_xnor_acc_ctrl;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int BA    = 16;
  localparam int BW    = 16;
  localparam int BD    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  sip_xnor_acc_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W), .BITS_ACT(BA), .BITS_WEIGHT(BW),
                         .BITS_SIP_DOT_ADDER(BD)) bus ();

  sip_xnor_acc_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W), .BITS_ACT(BA), .BITS_WEIGHT(BW),
                      .BITS_SIP_DOT_ADDER(BD)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  assign bus.i_DotSum = bus.o_Act[7:0] ^ bus.o_Weight[7:0];

  int                n_checks = 0;
  int                n_fail = 0;
  logic [BA-1:0]     job_act[$];
  logic [BW-1:0]     job_wt[$];
  int                job_gap[$];
  logic [31:0]       exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res32();
    return {{(32-ACC_W){bus.o_Result[ACC_W-1]}}, bus.o_Result};
  endfunction

  function automatic void add_chunk(input logic [BA-1:0] a, input logic [BW-1:0] w, input int gap);
    job_act.push_back(a);
    job_wt.push_back(w);
    job_gap.push_back(gap);
  endfunction

  function automatic void clear_job();
    job_act.delete();
    job_wt.delete();
    job_gap.delete();
  endfunction

  // Reference: running sum clamped to the signed ACC_W range after every chunk.
  function automatic void model(output logic [31:0] res, output logic sat);
    int acc;
    int amax;
    int amin;
    logic signed [7:0] d8;
    acc  = 0;
    sat  = 1'b0;
    amax = (1 <<< (ACC_W - 1)) - 1;
    amin = -(1 <<< (ACC_W - 1));
    foreach (job_act[i]) begin
      d8  = job_act[i][7:0] ^ job_wt[i][7:0];
      acc = acc + int'(d8);
      if (acc > amax) begin acc = amax; sat = 1'b1; end
      if (acc < amin) begin acc = amin; sat = 1'b1; end
    end
    res = 32'(acc);
  endfunction

  // Entered and left at a negedge.
  task automatic run_job(input int num, input int ready_delay);
    logic [31:0] exp_res;
    logic [31:0] got_res;
    logic        exp_sat;
    logic [2:0]  cfg;
    model(exp_res, exp_sat);
    exp_q.push_back(exp_res);
    cfg = 3'($urandom_range(0, 7));
    bus.i_Start     = 1'b1;
    bus.i_NumChunks = CNT_W'(num);
    {bus.i_Mode, bus.i_SignI, bus.i_Bin} = cfg;
    @(negedge clk);
    bus.i_Start = 1'b0;
    {bus.i_Mode, bus.i_SignI, bus.i_Bin} = ~cfg;
    chk("start_busy", 32'(bus.o_Busy), 32'd1);
    chk("start_cfg", 32'({bus.o_Mode, bus.o_SignI, bus.o_Bin}), 32'(cfg));
    if (num == 0) begin
      chk("zero_in_ready", 32'(bus.o_InReady), 32'd0);
    end else begin
      for (int i = 0; i < num; i++) begin
        for (int g = 0; g < job_gap[i]; g++) begin
          bus.i_InValid = 1'b0;
          bus.i_Act     = BA'($urandom);
          bus.i_Weight  = BW'($urandom);
          @(negedge clk);
          if (i > 0) chk("act_hold", 32'(bus.o_Act), 32'(job_act[i-1]));
        end
        chk("in_ready", 32'(bus.o_InReady), 32'd1);
        bus.i_InValid = 1'b1;
        bus.i_Act     = job_act[i];
        bus.i_Weight  = job_wt[i];
        @(negedge clk);
        chk("act_reg", 32'(bus.o_Act), 32'(job_act[i]));
        chk("wt_reg", 32'(bus.o_Weight), 32'(job_wt[i]));
      end
      bus.i_InValid = 1'b0;
      bus.i_Act     = BA'($urandom);
      chk("drain_out_valid", 32'(bus.o_OutValid), 32'd0);
      chk("drain_in_ready", 32'(bus.o_InReady), 32'd0);
      @(negedge clk);
    end
    exp_res = exp_q.pop_front();
    chk("done_valid", 32'(bus.o_OutValid), 32'd1);
    chk("result", res32(), exp_res);
    chk("sat", 32'(bus.o_Sat), 32'(exp_sat));
    chk("done_cfg", 32'({bus.o_Mode, bus.o_SignI, bus.o_Bin}), 32'(cfg));
    got_res = res32();
    for (int k = 0; k < ready_delay; k++) begin
      bus.i_Start = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(bus.o_OutValid), 32'd1);
      chk("bp_result", res32(), got_res);
      chk("bp_sat", 32'(bus.o_Sat), 32'(exp_sat));
    end
    bus.i_Start    = 1'b0;
    bus.i_OutReady = 1'b1;
    @(negedge clk);
    bus.i_OutReady = 1'b0;
    chk("idle_valid", 32'(bus.o_OutValid), 32'd0);
    chk("idle_busy", 32'(bus.o_Busy), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.o_InReady), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.o_OutValid), 32'd0);
    chk({tag, "_sat"}, 32'(bus.o_Sat), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd0);
    chk({tag, "_result"}, res32(), 32'd0);
    chk({tag, "_act_wt"}, 32'({bus.o_Act, bus.o_Weight}), 32'd0);
    chk({tag, "_cfg"}, 32'({bus.o_Mode, bus.o_SignI, bus.o_Bin}), 32'd0);
  endtask

  initial begin
    bus.i_Start     = 1'b0;
    bus.i_NumChunks = '0;
    bus.i_Mode      = 1'b0;
    bus.i_SignI     = 1'b0;
    bus.i_Bin       = 1'b0;
    bus.i_InValid   = 1'b0;
    bus.i_Act       = '0;
    bus.i_Weight    = '0;
    bus.i_OutReady  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job with 5 cycles of result backpressure and a start pulse held during DONE.
    clear_job();
    add_chunk(16'h0005, 16'h0000, 0);
    add_chunk(16'h00FE, 16'h0000, 0);
    add_chunk(16'h0007, 16'h0000, 0);
    run_job(3, 5);

    // Valid pattern 1,0,0,1,0,0,... with a dot sum of 1 per chunk.
    clear_job();
    for (int i = 0; i < 4; i++) add_chunk(16'h1201, 16'h1200, (i == 0) ? 0 : 2);
    run_job(4, 0);

    clear_job();
    run_job(0, 1);

    clear_job();
    add_chunk(16'h0064, 16'h0000, 0);
    add_chunk(16'h0064, 16'h0000, 0);
    run_job(2, 0);

    clear_job();
    add_chunk(16'h00FD, 16'h0000, 0);
    run_job(1, 0);

    for (int j = 0; j < 8; j++) begin
      int n;
      clear_job();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) add_chunk(BA'($urandom), BW'($urandom), $urandom_range(0, 2));
      run_job(n, $urandom_range(0, 3));
    end

    // Reset asserted after 2 of 5 chunks, between clock edges.
    clear_job();
    bus.i_Start     = 1'b1;
    bus.i_NumChunks = CNT_W'(5);
    {bus.i_Mode, bus.i_SignI, bus.i_Bin} = 3'b111;
    @(negedge clk);
    bus.i_Start   = 1'b0;
    bus.i_InValid = 1'b1;
    bus.i_Act     = 16'h0003;
    @(negedge clk);
    bus.i_Act     = 16'h0004;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("async_reset");
    bus.i_InValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_chunk(16'h0009, 16'h0000, 0);
    run_job(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sip_xnor_acc_ctrl.md
# sip_xnor_acc_ctrl

Sequencing controller for the binary/XNOR SIP dot-product datapath (sip_dot_xnor1 / sip_dot_xnor2 feeding sip_dot_adder). It accepts a job descriptor, streams a programmed number of activation/weight chunks through the datapath, and accumulates the per-chunk adder sums into a saturating accumulator. It returns one signed result per job over a valid/ready handshake. It sits between the tile-level scheduler and the combinational dot datapath, which it drives through registered operand outputs.

## Interface
- ACC_W, 24: accumulator/result width; must be ≥ `BITS_SIP_DOT_ADDER.
- CNT_W, 8: width of the chunk-count field.
- Widths `BITS_ACT, `BITS_WEIGHT and `BITS_SIP_DOT_ADDER come from parameters.v.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RSTn  in  1  asynchronous, active-low reset.
- i_Start  in  1  job start pulse; sampled only in IDLE.
- i_NumChunks  in  CNT_W  chunk count for the job, unsigned.
- i_Mode  in  1  0 = xnor1 datapath, 1 = xnor2 datapath.
- i_SignI  in  1  activation sign mode for xnor2.
- i_Bin  in  1  binary mode flag passed to the datapath.
- i_InValid  in  1  chunk valid.
- o_InReady  out  1  chunk ready.
- i_Act  in  `BITS_ACT  activation chunk.
- i_Weight  in  `BITS_WEIGHT  weight chunk.
- o_Act  out  `BITS_ACT  registered operand to the datapath.
- o_Weight  out  `BITS_WEIGHT  registered operand to the datapath.
- o_Mode, o_SignI, o_Bin  out  1 each  job configuration latched at start.
- i_DotSum  in  signed `BITS_SIP_DOT_ADDER  combinational sip_dot_adder output for o_Act/o_Weight.
- o_OutValid  out  1  result valid.
- i_OutReady  in  1  result ready.
- o_Result  out  signed ACC_W  accumulated job result.
- o_Sat  out  1  saturation occurred during the job.
- o_Busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On i_Start, latch i_NumChunks, i_Mode, i_SignI and i_Bin; clear the accumulator, o_Sat and the chunk counter.
  - Go to RUN, or straight to DONE with o_Result = 0 if i_NumChunks = 0.
- RUN:
  - o_InReady = 1.
  - On a chunk handshake (i_InValid & o_InReady), register i_Act/i_Weight into o_Act/o_Weight, set the internal operand-valid flag, and increment the counter.
  - When the accepted chunk is chunk number NumChunks, go to DRAIN.
  - With no handshake, operand-valid clears and o_Act/o_Weight hold.
- Accumulate: in any cycle with operand-valid set, acc ← sat(acc + sign-extend(i_DotSum)).
  - sat clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Clamping sets o_Sat, which is sticky until the next start.
- DRAIN: one cycle that absorbs the last chunk's accumulate, then go to DONE.
- DONE:
  - o_OutValid = 1; o_Result and o_Sat stay stable.
  - On i_OutReady, go to IDLE.
- i_Start outside IDLE is ignored. i_InValid outside RUN is ignored (o_InReady = 0).
- Changing i_Mode/i_SignI/i_Bin mid-job has no effect; only the values latched at start are used.
- Reset mid-job aborts the job. No partial result is emitted.

## Timing
- Reset values:
  - state = IDLE.
  - o_InReady, o_OutValid, o_Sat and o_Busy = 0.
  - o_Result = 0.
  - o_Act and o_Weight = 0.
  - o_Mode, o_SignI and o_Bin = 0.
- Config outputs are valid from the cycle after start.
- A chunk accepted at edge t appears on o_Act/o_Weight after t. i_DotSum is sampled and accumulated at edge t+1.
- Throughput is one chunk per cycle with back-to-back handshakes.
- Latency from the last chunk handshake to o_OutValid is 2 edges (operand register edge, then DRAIN).
- A zero-chunk job raises o_OutValid 1 edge after start.
- o_OutValid holds until i_OutReady. A new job can start at the earliest one cycle after the result handshake, in IDLE.
- o_Busy is registered and equals (state ≠ IDLE).

## Test plan
- Basic job: NumChunks = 3, mode 0; chunks back-to-back; model i_DotSum = 5, −2, 7 -> o_OutValid 2 cycles after the 3rd handshake, o_Result = 10, o_Sat = 0.
- Stalls: NumChunks = 4, i_InValid toggling 1,0,0,1,… with i_DotSum = 1 each -> o_Result = 4. No accumulate occurs on idle cycles, and o_Act holds during gaps.
- Backpressure: i_OutReady low for 5 cycles -> o_OutValid and o_Result stable for 5 cycles; IDLE on the cycle after ready rises; an i_Start during DONE is ignored.
- Saturation: ACC_W = 8, i_DotSum = 100, 100 -> o_Result = 127, o_Sat = 1. A new job with i_DotSum = −3 -> o_Result = −3, o_Sat = 0.
- Zero count: i_NumChunks = 0 -> o_OutValid one cycle after start, o_Result = 0, o_InReady never asserted.
- Reset mid-job: assert i_RSTn = 0 after 2 of 5 chunks -> all outputs return to their reset values immediately (asynchronous); after release, a fresh 1-chunk job with i_DotSum = 9 gives o_Result = 9.
